// File: rtl/psum_accum_drain.sv
// psum_accum_drain: accumulates NUM_PASSES column-psum vectors per lane with
// signed saturation and optional ReLU. It then drains the finished frame one
// lane per cycle over a valid/ready stream. A separate output buffer lets the
// early passes of the next frame overlap the drain.
module psum_accum_drain #(
  parameter int DATA_BITWIDTH = 16,
  parameter int X_dim         = 5,
  parameter int NUM_PASSES    = 3,
  parameter int RELU_EN       = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clear,
  input  logic [DATA_BITWIDTH*X_dim-1:0] psum_in,
  input  logic                           psum_valid,
  output logic                           psum_ready,
  output logic [DATA_BITWIDTH-1:0]       out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_last,
  output logic [7:0]                     pass_cnt,
  output logic                           frame_done
);

  localparam int W  = DATA_BITWIDTH;
  localparam int LW = (X_dim > 1) ? $clog2(X_dim) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(X_dim - 1);
  localparam logic [7:0]    LAST_PASS = 8'(NUM_PASSES - 1);
  localparam logic [W-1:0]  SAT_MAX   = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  SAT_MIN   = {1'b1, {(W-1){1'b0}}};

  logic [W-1:0]  r_acc  [X_dim];
  logic [W-1:0]  r_obuf [X_dim];
  logic [7:0]    r_pass_cnt;
  logic          r_obuf_full;
  logic [LW-1:0] r_lane_idx;
  logic          r_frame_done;
  logic          r_psum_ready;

  logic [W-1:0]  w_lane_in   [X_dim];
  logic [W:0]    w_ext       [X_dim];
  logic [W-1:0]  w_sum       [X_dim];
  logic [W-1:0]  w_final_val [X_dim];
  logic          w_accept;
  logic          w_xfer;
  logic          w_last_xfer;
  logic          w_final_pass;
  logic [7:0]    w_pass_cnt_nxt;
  logic          w_obuf_full_nxt;
  logic [LW-1:0] w_lane_idx_nxt;
  logic          w_ready_nxt;

  assign w_accept     = psum_valid & r_psum_ready;
  assign w_xfer       = r_obuf_full & out_ready;
  assign w_last_xfer  = w_xfer && (r_lane_idx == LAST_LANE);
  assign w_final_pass = (r_pass_cnt == LAST_PASS);

  assign psum_ready = r_psum_ready;
  assign out_valid  = r_obuf_full;
  assign out_data   = r_obuf[r_lane_idx];
  assign out_last   = r_obuf_full && (r_lane_idx == LAST_LANE);
  assign pass_cnt   = r_pass_cnt;
  assign frame_done = r_frame_done;

  // Per-lane saturating add (pass 0 loads directly) and optional ReLU
  always_comb begin
    for (int unsigned k = 0; k < X_dim; k++) begin
      w_lane_in[k] = psum_in[k*W +: W];
      w_ext[k]     = {r_acc[k][W-1], r_acc[k]} + {w_lane_in[k][W-1], w_lane_in[k]};
      if (r_pass_cnt == '0) begin
        w_sum[k] = w_lane_in[k];
      end else if (w_ext[k][W] != w_ext[k][W-1]) begin
        w_sum[k] = w_ext[k][W] ? SAT_MIN : SAT_MAX;
      end else begin
        w_sum[k] = w_ext[k][W-1:0];
      end
      w_final_val[k] = ((RELU_EN != 0) && w_sum[k][W-1]) ? '0 : w_sum[k];
    end
  end

  // Next-state for pass counter, output-buffer occupancy and drain lane index
  always_comb begin
    w_pass_cnt_nxt  = r_pass_cnt;
    w_obuf_full_nxt = r_obuf_full;
    w_lane_idx_nxt  = r_lane_idx;
    if (clear) begin
      w_pass_cnt_nxt  = '0;
      w_obuf_full_nxt = 1'b0;
      w_lane_idx_nxt  = '0;
    end else begin
      if (w_xfer) begin
        if (w_last_xfer) begin
          w_obuf_full_nxt = 1'b0;
          w_lane_idx_nxt  = '0;
        end else begin
          w_lane_idx_nxt = r_lane_idx + 1'b1;
        end
      end
      // A final-pass accept only happens with the buffer empty, so it never
      // collides with a transfer; it is ordered last to keep that explicit.
      if (w_accept) begin
        if (w_final_pass) begin
          w_pass_cnt_nxt  = '0;
          w_obuf_full_nxt = 1'b1;
          w_lane_idx_nxt  = '0;
        end else begin
          w_pass_cnt_nxt = r_pass_cnt + 8'd1;
        end
      end
    end
    // Ready is registered from next state so it never depends on out_ready
    w_ready_nxt = !((w_pass_cnt_nxt == LAST_PASS) && w_obuf_full_nxt);
  end

  // Control registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pass_cnt   <= '0;
      r_obuf_full  <= 1'b0;
      r_lane_idx   <= '0;
      r_frame_done <= 1'b0;
      r_psum_ready <= 1'b0;
    end else begin
      r_pass_cnt   <= w_pass_cnt_nxt;
      r_obuf_full  <= w_obuf_full_nxt;
      r_lane_idx   <= w_lane_idx_nxt;
      r_frame_done <= !clear && w_last_xfer;
      r_psum_ready <= w_ready_nxt;
    end
  end

  // Accumulator bank and output buffer, written only on a non-cleared accept
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 0; k < X_dim; k++) begin
        r_acc[k]  <= '0;
        r_obuf[k] <= '0;
      end
    end else if (!clear && w_accept) begin
      for (int unsigned k = 0; k < X_dim; k++) begin
        if (w_final_pass) begin
          r_obuf[k] <= w_final_val[k];
        end else begin
          r_acc[k] <= w_sum[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_psum_accum_drain.sv
// Directed bench for psum_accum_drain: one instance with ReLU, one without,
// driven by identical stimulus.
module tb_psum_accum_drain;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic [79:0] psum_in;
  logic        psum_valid;
  logic        out_ready;

  logic        psum_ready,    psum_ready_nr;
  logic [15:0] out_data,      out_data_nr;
  logic        out_valid,     out_valid_nr;
  logic        out_last,      out_last_nr;
  logic [7:0]  pass_cnt,      pass_cnt_nr;
  logic        frame_done,    frame_done_nr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  psum_accum_drain #(.DATA_BITWIDTH(16), .X_dim(5), .NUM_PASSES(3), .RELU_EN(1)) u_dut (
    .clk(clk), .reset(reset), .clear(clear), .psum_in(psum_in), .psum_valid(psum_valid),
    .psum_ready(psum_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .pass_cnt(pass_cnt), .frame_done(frame_done)
  );

  psum_accum_drain #(.DATA_BITWIDTH(16), .X_dim(5), .NUM_PASSES(3), .RELU_EN(0)) u_dut_nr (
    .clk(clk), .reset(reset), .clear(clear), .psum_in(psum_in), .psum_valid(psum_valid),
    .psum_ready(psum_ready_nr), .out_data(out_data_nr), .out_valid(out_valid_nr),
    .out_ready(out_ready), .out_last(out_last_nr), .pass_cnt(pass_cnt_nr),
    .frame_done(frame_done_nr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [79:0] mk(input logic [15:0] l0, l1, l2, l3, l4);
    return {l4, l3, l2, l1, l0};
  endfunction

  task automatic idle_inputs();
    logic [95:0] g;
    g          = {$urandom(), $urandom(), $urandom()};
    psum_valid = 1'b0;
    psum_in    = g[79:0];
  endtask

  // Present one vector, wait (bounded) for ready, let one edge accept it
  task automatic push(input logic [79:0] v);
    int cnt;
    cnt        = 0;
    psum_valid = 1'b1;
    psum_in    = v;
    while (!psum_ready && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    chk("push_ready", psum_ready, 1);
    @(negedge clk);
    idle_inputs();
  endtask

  // Drain one frame with out_ready=1, checking every beat on both instances
  task automatic drain(input logic [79:0] e, input logic [79:0] enr);
    int cnt;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cnt = 0;
      while (!out_valid && cnt < 40) begin
        @(negedge clk);
        cnt++;
      end
      chk($sformatf("valid_l%0d", k), out_valid, 1);
      chk($sformatf("valid_nr_l%0d", k), out_valid_nr, 1);
      chk($sformatf("data_l%0d", k), out_data, e[k*16 +: 16]);
      chk($sformatf("data_nr_l%0d", k), out_data_nr, enr[k*16 +: 16]);
      chk($sformatf("last_l%0d", k), out_last, (k == 4));
      chk($sformatf("last_nr_l%0d", k), out_last_nr, (k == 4));
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("frame_done", frame_done, 1);
    chk("frame_done_nr", frame_done_nr, 1);
    chk("valid_after_drain", out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_pass_cnt", pass_cnt, 0);
    chk("rst_pass_cnt_nr", pass_cnt_nr, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_ready", psum_ready, 0);
    reset = 1'b1;
    #1;
    chk("ready_at_release", psum_ready, 0);
    @(negedge clk);
    chk("ready_after_release", psum_ready, 1);

    // Test 1: lane k gets k+1 on each pass
    push(mk(1, 2, 3, 4, 5));
    chk("t1_pass1", pass_cnt, 1);
    push(mk(1, 2, 3, 4, 5));
    chk("t1_pass2", pass_cnt, 2);
    push(mk(1, 2, 3, 4, 5));
    chk("t1_pass0", pass_cnt, 0);
    drain(mk(3, 6, 9, 12, 15), mk(3, 6, 9, 12, 15));
    @(negedge clk);
    chk("t1_done_pulse_end", frame_done, 0);

    // Tests 2/3: saturation both ways, ReLU vs pass-through
    push(mk(16'h7000, 16'h9000, 16'd5,    16'd100,  16'hFFFF));
    push(mk(16'h7000, 16'h9000, 16'hFFF9, 16'd200,  16'hFFFF));
    push(mk(16'h7000, 16'h9000, 16'hFFFD, 16'hFFCE, 16'hFFFF));
    drain(mk(16'h7FFF, 16'h0000, 16'h0000, 16'd250, 16'h0000),
          mk(16'h7FFF, 16'h8000, 16'hFFFB, 16'd250, 16'hFFFD));

    // Test 4: overlap with a stalled drain, then final-pass backpressure
    push(mk(0, 1, 2, 3, 4));
    push(mk(0, 1, 2, 3, 4));
    push(mk(0, 1, 2, 3, 4));
    chk("t4_full_valid", out_valid, 1);
    chk("t4_full_data", out_data, 0);
    chk("t4_ready_p0", psum_ready, 1);
    push(mk(100, 101, 102, 103, 104));
    chk("t4_ready_p1", psum_ready, 1);
    push(mk(20, 20, 20, 20, 20));
    chk("t4_pass_cnt2", pass_cnt, 2);
    chk("t4_ready_blocked", psum_ready, 0);
    psum_valid = 1'b1;
    psum_in    = mk(1, 1, 1, 1, 1);
    out_ready  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t4_stall_ready", psum_ready, 0);
      chk("t4_stall_pass", pass_cnt, 2);
      chk("t4_stall_data", out_data, 0);
    end
    drain(mk(0, 3, 6, 9, 12), mk(0, 3, 6, 9, 12));
    chk("t4_bubble_ready", psum_ready, 1);
    chk("t4_bubble_pass", pass_cnt, 2);
    @(negedge clk);
    idle_inputs();
    chk("t4_final_accepted_valid", out_valid, 1);
    chk("t4_final_accepted_pass", pass_cnt, 0);
    drain(mk(121, 122, 123, 124, 125), mk(121, 122, 123, 124, 125));

    // Test 5: reset during the third drain beat
    push(mk(1, 2, 3, 4, 5));
    push(mk(1, 2, 3, 4, 5));
    push(mk(1, 2, 3, 4, 5));
    push(mk(9, 9, 9, 9, 9));
    chk("t5_pass_cnt1", pass_cnt, 1);
    out_ready = 1'b1;
    chk("t5_beat0", out_data, 3);
    @(negedge clk);
    chk("t5_beat1", out_data, 6);
    @(negedge clk);
    chk("t5_beat2", out_data, 9);
    chk("t5_beat2_valid", out_valid, 1);
    reset = 1'b0;
    #1;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_pass", pass_cnt, 0);
    chk("t5_rst_data", out_data, 0);
    chk("t5_rst_last", out_last, 0);
    out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_ready_after", psum_ready, 1);
    chk("t5_valid_after", out_valid, 0);
    push(mk(2, 3, 4, 5, 6));
    push(mk(2, 3, 4, 5, 6));
    push(mk(2, 3, 4, 5, 6));
    drain(mk(6, 9, 12, 15, 18), mk(6, 9, 12, 15, 18));

    // Test 6: clear wins over a same-cycle accept at pass_cnt=1
    push(mk(50, 50, 50, 50, 50));
    chk("t6_pass_cnt1", pass_cnt, 1);
    psum_valid = 1'b1;
    psum_in    = mk(1000, 1000, 1000, 1000, 1000);
    clear      = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    idle_inputs();
    chk("t6_clear_pass", pass_cnt, 0);
    chk("t6_clear_ready", psum_ready, 1);
    chk("t6_clear_valid", out_valid, 0);
    push(mk(7, 7, 7, 7, 7));
    push(mk(7, 7, 7, 7, 7));
    push(mk(7, 7, 7, 7, 7));
    drain(mk(21, 21, 21, 21, 21), mk(21, 21, 21, 21, 21));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
